instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction sequencer that drives the control decoder's `instr` and `ldImmed` inputs.
- Owns the program counter and reads 9-bit words from an asynchronous instruction ROM.
- Issues one opcode/operand per cycle. Handles two-word load-immediate sequences, branch redirection via a target lookup table, and halt on the done opcode.

Parameters:
- PC_W, 10, program counter / ROM address width.
- IW, 9, instruction word width.
- OPW, 4, opcode width (instr[8:5]).
- LUT_W, 5, branch-target LUT index width (instr[4:0]).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse to begin execution at PC 0.
- branch_taken  input  1  decoder Branch ANDed with the ALU condition, for the current issued instruction.
- rom_addr  output  PC_W  = pc, combinational.
- rom_data  input  IW  ROM word at rom_addr, same cycle.
- instr  output  OPW  opcode to the decoder (rom_data[8:5] in RUN, else 0).
- operand  output  5  rom_data[4:0] in RUN, else 0.
- ld_immed  output  1  high only in IMM state.
- imm_value  output  8  rom_data[7:0] in IMM state, else 0.
- valid  output  1  an instruction or immediate is being issued this cycle.
- done  output  1  high in HALT.

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
  - Reset → state IDLE, pc=0.
  - All outputs 0 while in IDLE, except rom_addr which follows pc.
- States: IDLE, RUN, IMM, HALT. Registered state and pc; outputs are decoded combinationally from state and rom_data.
- IDLE:
  - start=1 → RUN, pc=0.
  - Otherwise hold.
- RUN: valid=1; instr/operand come from rom_data. At the edge:
  - opcode 1111 (done) → HALT, pc held.
  - opcode 1110 (ldi prefix) → IMM, pc+1.
  - opcode 0001–0011 with branch_taken=1 → pc = lut[operand], stay RUN.
  - all else → pc+1.
- branch_taken is ignored for non-branch opcodes.
- IMM:
  - valid=1, ld_immed=1, instr=0, operand=0, imm_value=rom_data[7:0].
  - Next edge → RUN, pc+1.
  - branch_taken is ignored in IMM.
- HALT:
  - done=1, valid=0.
  - start=1 → RUN, pc=0 (restart). Otherwise hold.
- Latency: one instruction issued per cycle; a taken branch costs 0 bubbles, with the target issued the cycle after the branch.
- Wrap: pc+1 at 2^PC_W−1 wraps to 0 silently.
- start in RUN or IMM is ignored.
- Reset has priority over all inputs in every state, including mid-IMM. A pending immediate is discarded.
- LUT:
  - 32 entries × PC_W, constant contents from the package.
  - Index = operand.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- Defined:
  - Adds output `icount[15:0]`, reset to 0.
  - Increments on every cycle with valid=1 (IMM words count).
  - Saturates at 0xFFFF.
  - Cleared when start launches from IDLE or HALT.
- Undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Package `fetch_pkg`:
  - opcode localparams OP_BR0..OP_BR2 (0001–0011), OP_LDI (1110), OP_DONE (1111).
  - state enum {IDLE, RUN, IMM, HALT}.
  - branch LUT contents as a constant array.
- Sub-module `branch_lut`:
  - combinational, 5-bit index → PC_W target.
  - instantiated once.

Test Plan:
- Reset/start: assert reset 2 cycles → all outputs 0, pc=0. Pulse start → next cycle valid=1, rom_addr=0, instr=rom[0][8:5].
- Sequential run: ROM 0..3 = ALU ops (1000,1001,1100,1101) → instr follows in consecutive cycles, rom_addr 0,1,2,3.
- Load immediate: rom[4]=1110_xxxxx, rom[5]=0x0A5 → cycle N instr=1110, ld_immed=0; cycle N+1 ld_immed=1, imm_value=0xA5; cycle N+2 rom_addr=6.
- Branch: rom[6]=0001_00011, lut[3]=20, branch_taken=1 → next rom_addr=20. Repeat with branch_taken=0 → rom_addr=7. branch_taken=1 on opcode 1000 → no redirect.
- Halt/restart: rom[8]=1111_00000 → done=1 next cycle, rom_addr stays 8. start → RUN at pc 0. With INSTR_COUNT_EN, icount restarts at 0.
- Reset mid-IMM: reset asserted in IMM cycle → next cycle IDLE, ld_immed=0, pc=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared opcodes, FSM state type and branch-target table for the instruction fetch unit.
package fetch_pkg;
  localparam int PC_W  = 10;
  localparam int IW    = 9;
  localparam int OPW   = 4;
  localparam int LUT_W = 5;

  localparam logic [OPW-1:0] OP_BR0  = 4'b0001;
  localparam logic [OPW-1:0] OP_BR1  = 4'b0010;
  localparam logic [OPW-1:0] OP_BR2  = 4'b0011;
  localparam logic [OPW-1:0] OP_LDI  = 4'b1110;
  localparam logic [OPW-1:0] OP_DONE = 4'b1111;

  typedef enum logic [1:0] {IDLE, RUN, IMM, HALT} state_t;

  // Branch targets, indexed by the 5-bit operand of a branch opcode.
  localparam logic [PC_W-1:0] BR_LUT [32] = '{
    10'd8,   10'd12,  10'd16,  10'd20,  10'd24,  10'd28,  10'd32,  10'd36,
    10'd40,  10'd44,  10'd48,  10'd52,  10'd56,  10'd60,  10'd64,  10'd68,
    10'd72,  10'd76,  10'd80,  10'd84,  10'd88,  10'd92,  10'd96,  10'd100,
    10'd104, 10'd108, 10'd112, 10'd116, 10'd120, 10'd124, 10'd128, 10'd132
  };
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: ROM port, decoder-facing issue signals and control handshake.
interface instr_fetch_if #(
  parameter int PC_W  = 10,
  parameter int IW    = 9,
  parameter int OPW   = 4,
  parameter int LUT_W = 5
);
  logic             start;
  logic             branch_taken;
  logic [PC_W-1:0]  rom_addr;
  logic [IW-1:0]    rom_data;
  logic [OPW-1:0]   instr;
  logic [LUT_W-1:0] operand;
  logic             ld_immed;
  logic [7:0]       imm_value;
  logic             valid;
  logic             done;

  modport master (
    input  start, branch_taken, rom_data,
    output rom_addr, instr, operand, ld_immed, imm_value, valid, done
  );
  modport slave (
    output start, branch_taken, rom_data,
    input  rom_addr, instr, operand, ld_immed, imm_value, valid, done
  );
endinterface

// File: rtl/branch_lut.sv
// Combinational branch-target lookup: operand index to program counter.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int LUT_W = 5
) (
  input  logic [LUT_W-1:0] idx,
  output logic [PC_W-1:0]  target
);
  assign target = PC_W'(BR_LUT[idx]);
endmodule

// File: rtl/instr_fetch.sv
// Instruction sequencer: owns the pc, issues one ROM word per cycle to the decoder.
// Optional INSTR_COUNT_EN adds a saturating issued-instruction counter (icount).
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int IW    = 9,
  parameter int OPW   = 4,
  parameter int LUT_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  instr_fetch_if.master bus
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0]  icount
`endif
);
  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  target;
  logic [OPW-1:0]   op;
  logic [LUT_W-1:0] opnd;
  logic             is_br;
  logic             valid;
  logic             launch;

  assign op     = bus.rom_data[IW-1 -: OPW];
  assign opnd   = bus.rom_data[LUT_W-1:0];
  assign is_br  = (op == OP_BR0) || (op == OP_BR1) || (op == OP_BR2);
  assign valid  = (state == RUN) || (state == IMM);
  assign launch = bus.start && ((state == IDLE) || (state == HALT));

  branch_lut #(.PC_W(PC_W), .LUT_W(LUT_W)) u_lut (.idx(opnd), .target(target));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      case (state)
        IDLE, HALT:
          if (bus.start) begin
            state <= RUN;
            pc    <= '0;
          end
        RUN:
          if (op == OP_DONE) begin
            state <= HALT;
          end else if (op == OP_LDI) begin
            state <= IMM;
            pc    <= pc + PC_W'(1);
          end else if (is_br && bus.branch_taken) begin
            pc    <= target;
          end else begin
            pc    <= pc + PC_W'(1);
          end
        IMM: begin
          state <= RUN;
          pc    <= pc + PC_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.rom_addr  = pc;
    bus.instr     = '0;
    bus.operand   = '0;
    bus.ld_immed  = 1'b0;
    bus.imm_value = '0;
    bus.valid     = valid;
    bus.done      = (state == HALT);
    if (state == RUN) begin
      bus.instr   = op;
      bus.operand = opnd;
    end
    if (state == IMM) begin
      bus.ld_immed  = 1'b1;
      bus.imm_value = bus.rom_data[7:0];
    end
  end

`ifdef INSTR_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset || launch)
      icount <= '0;
    else if (valid && icount != 16'hFFFF)
      icount <= icount + 16'd1;
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table plus hand-written corner sequences.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_if #(.PC_W(10), .IW(9), .OPW(4), .LUT_W(5)) bus ();
  logic [8:0] rom [1024];
  assign bus.rom_data = rom[bus.rom_addr];

`ifdef INSTR_COUNT_EN
  logic [15:0] icount;
  instr_fetch dut (.clk(clk), .reset(reset), .bus(bus), .icount(icount));
`else
  instr_fetch dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  typedef struct {
    logic       start;
    logic       bt;
    logic [9:0] addr;
    logic [3:0] instr;
    logic [4:0] opnd;
    logic       ld;
    logic [7:0] imm;
    logic       v;
    logic       d;
  } vec_t;

  vec_t vecs [15];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(logic s, logic b, logic [9:0] a, logic [3:0] i,
                              logic [4:0] o, logic l, logic [7:0] m, logic v, logic d);
    vec_t r;
    r.start = s; r.bt = b; r.addr = a; r.instr = i; r.opnd = o;
    r.ld = l; r.imm = m; r.v = v; r.d = d;
    return r;
  endfunction

  function automatic logic [29:0] pack(vec_t e);
    return {e.addr, e.instr, e.opnd, e.ld, e.imm, e.v, e.d};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(string name, logic [29:0] exp);
    logic [29:0] got;
    got = {bus.rom_addr, bus.instr, bus.operand, bus.ld_immed, bus.imm_value, bus.valid, bus.done};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got addr=%0d instr=%h opnd=%h ld=%b imm=%h v=%b d=%b exp addr=%0d instr=%h opnd=%h ld=%b imm=%h v=%b d=%b",
               name, got[29:20], got[19:16], got[15:11], got[10], got[9:2], got[1], got[0],
               exp[29:20], exp[19:16], exp[15:11], exp[10], exp[9:2], exp[1], exp[0]);
    end
  endtask

`ifdef INSTR_COUNT_EN
  task automatic chk_cnt(string name, logic [15:0] exp);
    checks++;
    if (icount !== exp) begin
      failures++;
      $display("FAIL %s got icount=%0d exp=%0d", name, icount, exp);
    end
  endtask
`endif

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
    rom[0]  = 9'h100; rom[1]  = 9'h121; rom[2]  = 9'h182; rom[3]  = 9'h1A3;
    rom[4]  = 9'h1C0; rom[5]  = 9'h0A5; rom[6]  = 9'h023; rom[7]  = 9'h03F;
    rom[8]  = 9'h1E0; rom[20] = 9'h105; rom[21] = 9'h041; rom[22] = 9'h060;

    //            start bt addr instr opnd ld imm  v  d
    vecs[0]  = mk(1, 0, 0,  4'h0, 0, 0, 8'h00, 0, 0);  // IDLE, launch
    vecs[1]  = mk(0, 0, 0,  4'h8, 0, 0, 8'h00, 1, 0);
    vecs[2]  = mk(0, 0, 1,  4'h9, 1, 0, 8'h00, 1, 0);
    vecs[3]  = mk(0, 0, 2,  4'hC, 2, 0, 8'h00, 1, 0);
    vecs[4]  = mk(0, 1, 3,  4'hD, 3, 0, 8'h00, 1, 0);  // bt on ALU op ignored
    vecs[5]  = mk(0, 0, 4,  4'hE, 0, 0, 8'h00, 1, 0);  // ldi prefix
    vecs[6]  = mk(0, 1, 5,  4'h0, 0, 1, 8'hA5, 1, 0);  // immediate, bt ignored
    vecs[7]  = mk(0, 1, 6,  4'h1, 3, 0, 8'h00, 1, 0);  // taken branch -> 20
    vecs[8]  = mk(0, 1, 20, 4'h8, 5, 0, 8'h00, 1, 0);  // bt on 1000 ignored
    vecs[9]  = mk(1, 0, 21, 4'h2, 1, 0, 8'h00, 1, 0);  // not taken, start ignored
    vecs[10] = mk(0, 1, 22, 4'h3, 0, 0, 8'h00, 1, 0);  // taken -> lut[0]=8
    vecs[11] = mk(0, 0, 8,  4'hF, 0, 0, 8'h00, 1, 0);  // done opcode
    vecs[12] = mk(0, 0, 8,  4'h0, 0, 0, 8'h00, 0, 1);  // HALT hold
    vecs[13] = mk(1, 0, 8,  4'h0, 0, 0, 8'h00, 0, 1);  // restart
    vecs[14] = mk(0, 0, 0,  4'h8, 0, 0, 8'h00, 1, 0);

    reset = 1'b1; bus.start = 1'b0; bus.branch_taken = 1'b0;
    tick(); tick(); #1;
    chk("reset", {10'd0, 20'd0});
    reset = 1'b0;
    tick(); #1;
    chk("idle_hold", {10'd0, 20'd0});

    for (int i = 0; i < 15; i++) begin
      bus.start = vecs[i].start;
      bus.branch_taken = vecs[i].bt;
      #1;
      chk($sformatf("vec%0d", i), pack(vecs[i]));
`ifdef INSTR_COUNT_EN
      if (i == 12) chk_cnt("icount_halt", 16'd11);
      if (i == 14) chk_cnt("icount_restart", 16'd0);
`endif
      tick();
    end
    bus.start = 1'b0; bus.branch_taken = 1'b0;

    // pc1 -> pc6 through the ldi pair, then branch not taken at pc6
    for (int i = 0; i < 5; i++) tick();
    #1 chk("br_pc6", pack(mk(0, 0, 6, 4'h1, 3, 0, 8'h00, 1, 0)));
    tick(); #1;
    chk("br_not_taken", pack(mk(0, 0, 7, 4'h1, 5'd31, 0, 8'h00, 1, 0)));
    bus.branch_taken = 1'b1;
    tick(); #1;
    chk("br_lut31", pack(mk(0, 0, 132, 4'h0, 0, 0, 8'h00, 1, 0)));
    bus.branch_taken = 1'b0;

    // run zero-opcode words up to the top of the address space and wrap
    n = 0;
    while (bus.rom_addr != 10'd1023 && n < 2000) begin
      tick(); #1; n++;
    end
    chk("wrap_top", pack(mk(0, 0, 1023, 4'h0, 0, 0, 8'h00, 1, 0)));
    tick(); #1;
    chk("wrap_zero", pack(mk(0, 0, 0, 4'h8, 0, 0, 8'h00, 1, 0)));

    // reset during an immediate discards it
    reset = 1'b1; tick(); reset = 1'b0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #1 chk("imm_before_reset", pack(mk(0, 0, 5, 4'h0, 0, 1, 8'hA5, 1, 0)));
    reset = 1'b1; tick(); #1;
    chk("imm_reset", {10'd0, 20'd0});
`ifdef INSTR_COUNT_EN
    chk_cnt("icount_reset", 16'd0);
`endif
    reset = 1'b0;
    tick(); #1;
    chk("idle_after_reset", {10'd0, 20'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
